// File: rtl/ad9253_trig_capture.sv
// Triggered four-channel capture buffer for the AD9253 deserializer output (DCO domain).
// Optional macro AD9253_CAP_FORCE_TRIG_EN adds a Force_Trig input that forces a trigger in WAIT_TRIG.
module ad9253_trig_capture #(
  parameter int DEPTH    = 1024,
  parameter int AW       = 10,
  parameter int PRE_TRIG = 256
) (
  input  logic        DCO,
  input  logic        RST_N,
  input  logic        Data_VLD,
  input  logic [13:0] Data_CH0,
  input  logic [13:0] Data_CH1,
  input  logic [13:0] Data_CH2,
  input  logic [13:0] Data_CH3,
  input  logic        Arm,
  input  logic [1:0]  Trig_Ch,
  input  logic [13:0] Trig_Level,
  input  logic        Trig_Slope,
`ifdef AD9253_CAP_FORCE_TRIG_EN
  input  logic        Force_Trig,
`endif
  input  logic        Rd_Ready,
  output logic        Rd_Valid,
  output logic [55:0] Rd_Data,
  output logic        Rd_Last,
  output logic [2:0]  Cap_State,
  output logic        Done
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_READ = 3'd4;

  localparam logic [AW:0]   PRE_LAST  = (AW+1)'(PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_END  = AW'(1);
  localparam logic [AW:0]   RD_LAST   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   RD_TOTAL  = (AW+1)'(DEPTH);

  logic [55:0]   mem [DEPTH];
  logic [55:0]   ram_q_reg;
  logic [55:0]   wr_word;
  logic [2:0]    state_reg, state_next;
  logic [AW-1:0] wp_reg, rp_reg;
  logic [AW:0]   pre_cnt_reg, rd_cnt_reg;
  logic [AW-1:0] post_cnt_reg;
  logic [13:0]   prev_reg, cur_sample;
  logic          prev_vld_reg;
  logic          q_vld_reg, q_last_reg;
  logic [55:0]   out_data_reg;
  logic          out_vld_reg, out_last_reg, done_reg;
  logic          capturing, wr_en, level_hit, force_hit, trig_hit;
  logic          xfer, out_load, rd_en;

  assign wr_word   = {Data_CH3, Data_CH2, Data_CH1, Data_CH0};
  assign capturing = (state_reg == ST_PRE) || (state_reg == ST_WAIT) || (state_reg == ST_POST);
  assign wr_en     = Data_VLD && capturing;

  always_comb begin
    cur_sample = Data_CH0;
    case (Trig_Ch)
      2'd0: cur_sample = Data_CH0;
      2'd1: cur_sample = Data_CH1;
      2'd2: cur_sample = Data_CH2;
      2'd3: cur_sample = Data_CH3;
    endcase
  end

  assign level_hit = prev_vld_reg &&
                     (Trig_Slope ? ((prev_reg < Trig_Level) && (cur_sample >= Trig_Level))
                                 : ((prev_reg >= Trig_Level) && (cur_sample < Trig_Level)));
`ifdef AD9253_CAP_FORCE_TRIG_EN
  assign force_hit = Force_Trig;
`else
  assign force_hit = 1'b0;
`endif
  assign trig_hit = level_hit || force_hit;

  // Two-stage readout: RAM output register feeds the output register, so the
  // next word is already fetched when the consumer takes the current one.
  assign xfer     = out_vld_reg && Rd_Ready;
  assign out_load = q_vld_reg && (!out_vld_reg || xfer);
  assign rd_en    = (state_reg == ST_READ) && (rd_cnt_reg != RD_TOTAL) && (!q_vld_reg || out_load);

  always_ff @(posedge DCO) begin
    if (wr_en) mem[wp_reg] <= wr_word;
    if (rd_en) ram_q_reg <= mem[rp_reg];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (Arm) state_next = ST_PRE;
      ST_PRE:  if (wr_en && pre_cnt_reg == PRE_LAST) state_next = ST_WAIT;
      ST_WAIT: if (wr_en && trig_hit) state_next = ST_POST;
      ST_POST: if (wr_en && post_cnt_reg == POST_END) state_next = ST_READ;
      ST_READ: if (xfer && out_last_reg) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge DCO or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      wp_reg       <= '0;
      rp_reg       <= '0;
      pre_cnt_reg  <= '0;
      post_cnt_reg <= '0;
      rd_cnt_reg   <= '0;
      prev_reg     <= '0;
      prev_vld_reg <= 1'b0;
      q_vld_reg    <= 1'b0;
      q_last_reg   <= 1'b0;
      out_data_reg <= '0;
      out_vld_reg  <= 1'b0;
      out_last_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= xfer && out_last_reg;
      if (wr_en) begin
        wp_reg       <= wp_reg + 1'b1;
        prev_reg     <= cur_sample;
        prev_vld_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: if (Arm) begin
          wp_reg       <= '0;
          pre_cnt_reg  <= '0;
          prev_vld_reg <= 1'b0;
        end
        ST_PRE: if (wr_en) pre_cnt_reg <= pre_cnt_reg + 1'b1;
        ST_WAIT: if (wr_en && trig_hit) post_cnt_reg <= POST_INIT;
        ST_POST: if (wr_en) begin
          post_cnt_reg <= post_cnt_reg - 1'b1;
          // The slot after the final write holds the oldest sample of the record.
          if (post_cnt_reg == POST_END) begin
            rp_reg     <= wp_reg + 1'b1;
            rd_cnt_reg <= '0;
            q_vld_reg  <= 1'b0;
          end
        end
        ST_READ: begin
          if (rd_en) begin
            rp_reg     <= rp_reg + 1'b1;
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
            q_last_reg <= (rd_cnt_reg == RD_LAST);
          end
          q_vld_reg <= rd_en || (q_vld_reg && !out_load);
          if (out_load) begin
            out_data_reg <= ram_q_reg;
            out_last_reg <= q_last_reg;
            out_vld_reg  <= 1'b1;
          end else if (xfer) begin
            out_vld_reg  <= 1'b0;
            out_last_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Rd_Valid  = out_vld_reg;
  assign Rd_Data   = out_data_reg;
  assign Rd_Last   = out_last_reg;
  assign Cap_State = state_reg;
  assign Done      = done_reg;

endmodule

// File: tb/tb_ad9253_trig_capture.sv
// Directed bench for ad9253_trig_capture with a small buffer (DEPTH=16, PRE_TRIG=4).
module tb_ad9253_trig_capture;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int PRE_TRIG = 4;

  logic        DCO = 1'b0;
  logic        RST_N = 1'b0;
  logic        Data_VLD = 1'b0;
  logic [13:0] Data_CH0 = '0, Data_CH1 = '0, Data_CH2 = '0, Data_CH3 = '0;
  logic        Arm = 1'b0;
  logic [1:0]  Trig_Ch = '0;
  logic [13:0] Trig_Level = '0;
  logic        Trig_Slope = 1'b1;
  logic        Rd_Ready = 1'b0;
`ifdef AD9253_CAP_FORCE_TRIG_EN
  logic        Force_Trig = 1'b0;
`endif
  logic        Rd_Valid;
  logic [55:0] Rd_Data;
  logic        Rd_Last;
  logic [2:0]  Cap_State;
  logic        Done;

  ad9253_trig_capture #(.DEPTH(DEPTH), .AW(AW), .PRE_TRIG(PRE_TRIG)) dut (
    .DCO(DCO), .RST_N(RST_N), .Data_VLD(Data_VLD),
    .Data_CH0(Data_CH0), .Data_CH1(Data_CH1), .Data_CH2(Data_CH2), .Data_CH3(Data_CH3),
    .Arm(Arm), .Trig_Ch(Trig_Ch), .Trig_Level(Trig_Level), .Trig_Slope(Trig_Slope),
`ifdef AD9253_CAP_FORCE_TRIG_EN
    .Force_Trig(Force_Trig),
`endif
    .Rd_Ready(Rd_Ready), .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data), .Rd_Last(Rd_Last),
    .Cap_State(Cap_State), .Done(Done)
  );

  always #5 DCO = ~DCO;

  int total = 0;
  int bad = 0;
  logic [55:0] hist [0:63];
  logic [55:0] rec [0:DEPTH-1];

  task automatic tick();
    @(posedge DCO);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Data_VLD = 1'($urandom); Arm = 1'($urandom); Rd_Ready = 1'($urandom);
      Data_CH0 = 14'($urandom); Data_CH1 = 14'($urandom);
      Data_CH2 = 14'($urandom); Data_CH3 = 14'($urandom);
      Trig_Ch = 2'($urandom); Trig_Level = 14'($urandom); Trig_Slope = 1'($urandom);
      tick();
    end
    total++; if (Rd_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", Rd_Valid); end
    total++; if (Rd_Data !== 56'd0) begin bad++; $display("FAIL reset_data: got %h want 0", Rd_Data); end
    total++; if (Rd_Last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", Rd_Last); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", Done); end
    total++; if (Cap_State !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", Cap_State); end
    Data_VLD = 1'b0; Arm = 1'b0; Rd_Ready = 1'b0;
    RST_N = 1'b1;
    repeat (3) tick();
    total++; if (Cap_State !== 3'd0) begin bad++; $display("FAIL reset_release_state: got %0d want 0", Cap_State); end
    $display("reset test complete");
  endtask

  // Arm (optionally with a simultaneous Data_VLD that must be ignored), then send
  // hist[0 .. trig_n+DEPTH-PRE_TRIG-1]; sample trig_n is the expected trigger.
  task automatic drive_capture(input int trig_n, input logic arm_with_vld, input string name);
    int n_total;
    logic [2:0] exp_state;
    n_total = trig_n + DEPTH - PRE_TRIG;
    Arm = 1'b1; Data_VLD = arm_with_vld;
    {Data_CH3, Data_CH2, Data_CH1, Data_CH0} = {14'h3F00, 14'h3F00, 14'h3F00, 14'h3F00};
    tick();
    Arm = 1'b0; Data_VLD = 1'b0;
    total++; if (Cap_State !== 3'd1) begin bad++; $display("FAIL %s_arm_state: got %0d want 1", name, Cap_State); end
    for (int i = 0; i < n_total; i++) begin
      {Data_CH3, Data_CH2, Data_CH1, Data_CH0} = hist[i];
      Data_VLD = 1'b1;
      tick();
      Data_VLD = 1'b0;
      if (i < PRE_TRIG - 1) exp_state = 3'd1;
      else if (i < trig_n) exp_state = 3'd2;
      else if (i < n_total - 1) exp_state = 3'd3;
      else exp_state = 3'd4;
      total++;
      if (Cap_State !== exp_state) begin
        bad++; $display("FAIL %s_state_s%0d: got %0d want %0d", name, i, Cap_State, exp_state);
      end
      if ((i % 3 == 2) && (i < n_total - 1)) tick();
    end
  endtask

  task automatic read_record(input int trig_n, input logic bp, input logic arm_in_read, input string name);
    int got, done_cnt;
    logic stalled;
    logic [55:0] prev_data;
    logic [55:0] exp_word;
    Rd_Ready = 1'b0;
    Arm = arm_in_read;
    total++; if (Rd_Valid !== 1'b0) begin bad++; $display("FAIL %s_lat0: got %b want 0", name, Rd_Valid); end
    tick();
    Arm = 1'b0;
    total++; if (Rd_Valid !== 1'b0) begin bad++; $display("FAIL %s_lat1: got %b want 0", name, Rd_Valid); end
    total++; if (Cap_State !== 3'd4) begin bad++; $display("FAIL %s_read_state: got %0d want 4", name, Cap_State); end
    tick();
    total++; if (Rd_Valid !== 1'b1) begin bad++; $display("FAIL %s_lat2: got %b want 1", name, Rd_Valid); end
    got = 0; done_cnt = 0; stalled = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200 && got < DEPTH; cyc++) begin
      Rd_Ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (stalled) begin
        total++;
        if (Rd_Data !== prev_data) begin
          bad++; $display("FAIL %s_stall_hold: got %h want %h", name, Rd_Data, prev_data);
        end
      end
      if (Rd_Valid && Rd_Ready) begin
        exp_word = hist[trig_n - PRE_TRIG + got];
        rec[got] = Rd_Data;
        $display("%s word %0d data=%h last=%b", name, got, Rd_Data, Rd_Last);
        total++;
        if (Rd_Data !== exp_word) begin
          bad++; $display("FAIL %s_word%0d: got %h want %h", name, got, Rd_Data, exp_word);
        end
        total++;
        if (Rd_Last !== (got == DEPTH - 1)) begin
          bad++; $display("FAIL %s_last%0d: got %b want %b", name, got, Rd_Last, (got == DEPTH - 1));
        end
        got++;
      end
      stalled = Rd_Valid && !Rd_Ready;
      prev_data = Rd_Data;
      tick();
      if (Done) done_cnt++;
    end
    Rd_Ready = 1'b1;
    repeat (3) begin
      tick();
      if (Done) done_cnt++;
    end
    Rd_Ready = 1'b0;
    total++; if (got !== DEPTH) begin bad++; $display("FAIL %s_word_count: got %0d want %0d", name, got, DEPTH); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt); end
    total++; if (Cap_State !== 3'd0) begin bad++; $display("FAIL %s_end_state: got %0d want 0", name, Cap_State); end
    total++; if (Rd_Valid !== 1'b0) begin bad++; $display("FAIL %s_end_valid: got %b want 0", name, Rd_Valid); end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 64; i++)
      hist[i] = {14'(14'h3FFF - i), 14'(14'h2000 + i), 14'(i), 14'(i * 256)};
    Trig_Ch = 2'd0; Trig_Level = 14'h1000; Trig_Slope = 1'b1;
  endtask

  task automatic test_rising();
    load_ramp();
    drive_capture(16, 1'b1, "rise");
    read_record(16, 1'b0, 1'b0, "rise");
    total++; if (rec[0][13:0] !== 14'h0C00) begin bad++; $display("FAIL rise_first_ch0: got %h want 0c00", rec[0][13:0]); end
    total++; if (rec[4][13:0] !== 14'h1000) begin bad++; $display("FAIL rise_trig_ch0: got %h want 1000", rec[4][13:0]); end
    total++; if (rec[15][13:0] !== 14'h1B00) begin bad++; $display("FAIL rise_last_ch0: got %h want 1b00", rec[15][13:0]); end
  endtask

  task automatic test_pre_ignore();
    logic [13:0] ch0;
    for (int i = 0; i < 64; i++) begin
      case (i)
        0: ch0 = 14'h0000; 1: ch0 = 14'h0100; 2: ch0 = 14'h0200; 3: ch0 = 14'h0300;
        4: ch0 = 14'h0000; 5: ch0 = 14'h0200;
        default: ch0 = 14'(14'h1000 + i);
      endcase
      hist[i] = {14'(14'h0300 + i), 14'(14'h0200 + i), 14'(14'h0100 + i), ch0};
    end
    Trig_Ch = 2'd0; Trig_Level = 14'h0100; Trig_Slope = 1'b1;
    drive_capture(5, 1'b0, "preign");
    read_record(5, 1'b0, 1'b0, "preign");
    total++; if (rec[4][13:0] !== 14'h0200) begin bad++; $display("FAIL preign_trig_ch0: got %h want 0200", rec[4][13:0]); end
    total++; if (rec[0][13:0] !== 14'h0100) begin bad++; $display("FAIL preign_first_ch0: got %h want 0100", rec[0][13:0]); end
  endtask

  task automatic test_falling();
    logic [13:0] ch2;
    for (int i = 0; i < 64; i++) begin
      if (i < 10) ch2 = 14'h3FFF;
      else if (i == 10) ch2 = 14'h1FFF;
      else ch2 = 14'(14'h0800 + i);
      hist[i] = {14'(14'h0300 + i), ch2, 14'(14'h0100 + i), 14'(i)};
    end
    Trig_Ch = 2'd2; Trig_Level = 14'h2000; Trig_Slope = 1'b0;
    drive_capture(10, 1'b0, "fall");
    read_record(10, 1'b0, 1'b0, "fall");
    total++; if (rec[4][41:28] !== 14'h1FFF) begin bad++; $display("FAIL fall_trig_ch2: got %h want 1fff", rec[4][41:28]); end
    total++; if (rec[0][13:0] !== 14'h0006) begin bad++; $display("FAIL fall_first_ch0: got %h want 0006", rec[0][13:0]); end
    total++; if (rec[15][55:42] !== 14'h0315) begin bad++; $display("FAIL fall_last_ch3: got %h want 0315", rec[15][55:42]); end
  endtask

  task automatic test_backpressure();
    load_ramp();
    drive_capture(16, 1'b0, "bp");
    read_record(16, 1'b1, 1'b0, "bp");
  endtask

  task automatic test_reset_mid_post();
    load_ramp();
    Arm = 1'b1; tick(); Arm = 1'b0;
    for (int i = 0; i < 18; i++) begin
      {Data_CH3, Data_CH2, Data_CH1, Data_CH0} = hist[i];
      Data_VLD = 1'b1; tick(); Data_VLD = 1'b0;
    end
    total++; if (Cap_State !== 3'd3) begin bad++; $display("FAIL rstpost_pre_state: got %0d want 3", Cap_State); end
    RST_N = 1'b0;
    #1;
    total++; if (Cap_State !== 3'd0) begin bad++; $display("FAIL rstpost_state: got %0d want 0", Cap_State); end
    total++; if (Rd_Valid !== 1'b0) begin bad++; $display("FAIL rstpost_valid: got %b want 0", Rd_Valid); end
    tick();
    RST_N = 1'b1;
    tick();
    drive_capture(16, 1'b0, "rstpost");
    read_record(16, 1'b0, 1'b1, "rstpost");
  endtask

  initial begin
    test_reset();
    test_rising();
    test_pre_ignore();
    test_falling();
    test_backpressure();
    test_reset_mid_post();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad9253_trig_capture.md
Name: ad9253_trig_capture

Overview:
- Downstream of the AD9253 four-channel deserializer, in the DCO clock domain.
- Consumes the 14-bit Data_CH0..3 samples qualified by Data_VLD and stores them in a circular buffer.
- Detects a level-crossing trigger on a selectable channel, keeps PRE_TRIG pre-trigger samples plus the post-trigger samples, then streams the frozen record out over a valid/ready interface.

Parameters:
- DEPTH, 1024: buffer depth in sample sets; power of two, at least 4.
- AW, 10: address width; log2(DEPTH).
- PRE_TRIG, 256: samples kept before the trigger sample; 1 to DEPTH-2.

Ports:
- DCO  in  1  clock; ADC data clock, rising edge only.
- RST_N  in  1  reset; asynchronous assert, active-low.
- Data_VLD  in  1  sample-set strobe from the deserializer.
- Data_CH0..Data_CH3  in  14 each  channel samples, unsigned offset binary.
- Arm  in  1  start-capture pulse; honoured only in IDLE.
- Trig_Ch  in  2  trigger channel select (0..3).
- Trig_Level  in  14  trigger threshold.
- Trig_Slope  in  1  1 = rising, 0 = falling.
- Rd_Ready  in  1  consumer ready.
- Rd_Valid  out  1  readout word valid.
- Rd_Data  out  56  {CH3,CH2,CH1,CH0}.
- Rd_Last  out  1  marks the final (DEPTH-th) readout word.
- Cap_State  out  3  0 IDLE, 1 PRE, 2 WAIT_TRIG, 3 POST, 4 READ.
- Done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: state IDLE, write pointer 0, read pointer 0, all counters 0. Rd_Valid, Rd_Data, Rd_Last, Done and Cap_State are all 0.
- Writes occur only in PRE, WAIT_TRIG and POST, and only on Data_VLD. A write stores mem[wp] <= {CH3..CH0}, then wp <= wp+1 mod DEPTH.
- IDLE: Arm=1 -> PRE. Clears wp, pre count and the prev-valid flag.
- PRE: each write increments the pre count. When the PRE_TRIG-th write completes -> WAIT_TRIG. Triggers are ignored in PRE, but the prev sample is still tracked.
- Trigger detect:
  - cur = selected channel.
  - prev = selected channel on the previous Data_VLD; it is valid only after the first write since Arm.
  - Rising: prev < Trig_Level and cur >= Trig_Level. Falling: prev >= Trig_Level and cur < Trig_Level.
  - Comparisons are unsigned 14-bit.
  - Trig_Ch, Trig_Level and Trig_Slope are sampled live.
- WAIT_TRIG: writes continue and wrap. On a detect, the triggering sample is written (the trigger sample), post count <= DEPTH-PRE_TRIG-1, and the state goes to POST.
- POST: each write decrements post count. When a write occurs with post count 0 -> READ, with rp <= wp (the next write address), which is the oldest stored sample.
- Record layout: exactly PRE_TRIG samples before the trigger, the trigger sample at readout index PRE_TRIG, DEPTH total.
- READ:
  - Synchronous RAM with a 1-cycle read; the output register is prefetched.
  - First Rd_Valid appears 2 cycles after entering READ.
  - A word transfers when Rd_Valid and Rd_Ready are both 1.
  - While Rd_Valid=1 and Rd_Ready=0, Rd_Data and Rd_Last hold stable.
  - Back-to-back transfers at 1 word/cycle are sustained while Rd_Ready=1.
  - Rd_Last=1 only with the DEPTH-th word. On its transfer: Rd_Valid <= 0, Done pulses 1 cycle, state -> IDLE.
- Data_VLD is ignored in IDLE and READ. Arm outside IDLE is ignored.
- Arm and Data_VLD in the same IDLE cycle: the sample is not written; capture starts with the next Data_VLD.
- A reset assertion at any point aborts immediately to the reset state; buffer contents are undefined.

Optional Feature:
- Macro: AD9253_CAP_FORCE_TRIG_EN.
- Defined: adds input Force_Trig (1 bit). In WAIT_TRIG, Force_Trig=1 on a Data_VLD cycle forces a trigger on that sample, ORed with the level detect. It is ignored in other states.
- Not defined: the port is absent; only the level detect triggers.

Test Plan:
- Bench parameters: DEPTH=16, AW=4, PRE_TRIG=4.
1. Reset: hold RST_N=0 with random inputs -> Rd_Valid=0, Rd_Data=0, Done=0, Cap_State=0. Release RST_N -> Cap_State stays 0.
2. Rising trigger: Trig_Ch=0, Trig_Level=0x1000, Trig_Slope=1, CH0=n*0x100 each Data_VLD (n=0..), Arm at start, Rd_Ready=1.
   - Trigger fires at n=16.
   - 16 words read with CH0 = 0x0C00..0x1B00; word 4 = 0x1000.
   - Rd_Last on the 16th word; Done pulses once.
3. Crossing in PRE ignored: Trig_Level=0x0100, CH0 ramps 0,0x100,0x200,... so it crosses at n=1 in PRE -> stays WAIT_TRIG. Drive CH0=0 then 0x0200 -> trigger fires; word 4 CH0 = 0x0200.
4. Falling on CH2: Trig_Ch=2, Trig_Slope=0, Trig_Level=0x2000. CH2 holds 0x3FFF, then 0x1FFF at sample 10 -> trigger on sample 10; word 4 CH2 = 0x1FFF; other channels read back intact.
5. Backpressure: Rd_Ready pattern 1,0,0,1 repeating -> no word lost or duplicated, Rd_Data stable during stalls, exactly 16 transfers.
6. Reset mid-POST: assert RST_N=0 with Cap_State=3 -> Cap_State=0, Rd_Valid=0. A new Arm then completes a clean capture. Arm pulsed during READ has no effect.
